ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu.sv | 129 ++++++++++++
 tb/tb_ifu.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds datapath widths, the default reset PC and the fetch FSM state encoding.
package ifu_pkg;

    localparam int XLEN    = 64;
    localparam int INST_DW = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: issues one fetch at a time and holds each
// instruction for the decoder, with redirect and fault handling.
// Ports:
//   clk, rst                        clock, async active-high reset
//   redirect_valid, redirect_pc     branch/jump redirect
//   imem_req_valid/ready/addr       fetch request channel
//   imem_rsp_valid/data/err         fetch response (no backpressure)
//   out_valid/ready                 decoder handshake
//   out_instr, out_pc, out_fault    held instruction, its PC and fault flag
module ifu
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INST_DW-1:0] imem_rsp_data,
    input  logic               imem_rsp_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INST_DW-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_fault
);

    ifu_state_e         state, state_n;
    logic [XLEN-1:0]    pc, pc_n;
    logic               kill, kill_n;
    logic [INST_DW-1:0] instr_n;
    logic [XLEN-1:0]    opc_n;
    logic               fault_n;
    logic               misaligned;

    assign misaligned    = |pc[1:0];
    assign imem_req_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            kill      <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            out_fault <= 1'b0;
        end else begin
            pc        <= pc_n;
            kill      <= kill_n;
            out_instr <= instr_n;
            out_pc    <= opc_n;
            out_fault <= fault_n;
        end
    end

    always_comb begin
        state_n        = state;
        pc_n           = pc;
        kill_n         = kill;
        instr_n        = out_instr;
        opc_n          = out_pc;
        fault_n        = out_fault;
        imem_req_valid = 1'b0;
        out_valid      = 1'b0;
        unique case (state)
            S_REQ: begin
                imem_req_valid = !misaligned && !rst;
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                    // Request already handed off: its response must be dropped.
                    if (imem_req_valid && imem_req_ready) begin
                        kill_n  = 1'b1;
                        state_n = S_WAIT;
                    end
                end else if (misaligned) begin
                    state_n = S_HOLD;
                    instr_n = '0;
                    opc_n   = pc;
                    fault_n = 1'b1;
                end else if (imem_req_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    kill_n = 1'b0;
                    if (redirect_valid) begin
                        pc_n    = redirect_pc;
                        state_n = S_REQ;
                    end else if (kill) begin
                        state_n = S_REQ;
                    end else begin
                        state_n = S_HOLD;
                        instr_n = imem_rsp_err ? '0 : imem_rsp_data;
                        opc_n   = pc;
                        fault_n = imem_rsp_err;
                    end
                end else if (redirect_valid) begin
                    // Later redirects only retarget pc; one response still owed.
                    pc_n   = redirect_pc;
                    kill_n = 1'b1;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = S_REQ;
                end else if (out_ready) begin
                    pc_n    = pc + XLEN'(4);
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

endmodule

// File: tb/tb_ifu.sv
// Directed testbench for the instruction fetch unit.
// Drives fetch, stall, redirect, fault and reset scenarios against fixed expectations.
module tb_ifu;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_fault;

    int n_chk;
    int n_fail;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        out_ready      = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_pc !== 64'h0) begin n_fail++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
        n_chk++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL rst_out_instr: got %h want 0", out_instr); end
        n_chk++; if (out_fault !== 1'b0) begin n_fail++; $display("FAIL rst_out_fault: got %b want 0", out_fault); end
        rst = 1'b0;
        #1;
        n_chk++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rel_req_valid: got %b want 1", imem_req_valid); end
        n_chk++; if (imem_req_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL rel_req_addr: got %h want 80000000", imem_req_addr); end
    endtask

    task automatic test_basic_fetch;
        do_reset();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_noreq: got %b want 0", imem_req_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        n_chk++; if (out_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL basic_out_pc: got %h want 80000000", out_pc); end
        n_chk++; if (out_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL basic_out_instr: got %h want 00000013", out_instr); end
        n_chk++; if (out_fault !== 1'b0) begin n_fail++; $display("FAIL basic_out_fault: got %b want 0", out_fault); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_drop: got %b want 0", out_valid); end
        n_chk++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_next_valid: got %b want 1", imem_req_valid); end
        n_chk++; if (imem_req_addr !== 64'h8000_0004) begin n_fail++; $display("FAIL basic_next_addr: got %h want 80000004", imem_req_addr); end
    endtask

    task automatic test_stalls;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL req_stall_%0d: got v=%b a=%h want v=1 a=80000000", i, imem_req_valid, imem_req_addr); end
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL req_single_%0d: got %b want 0", i, imem_req_valid); end
            step();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        step();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (out_valid !== 1'b1 || out_instr !== 32'h0010_0093 || out_pc !== 64'h8000_0000 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL out_stall_%0d: got v=%b i=%h pc=%h rq=%b want 1 00100093 80000000 0", i, out_valid, out_instr, out_pc, imem_req_valid); end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_chk++; if (imem_req_addr !== 64'h8000_0004) begin n_fail++; $display("FAIL stall_next_addr: got %h want 80000004", imem_req_addr); end
    endtask

    task automatic test_redirect_wait;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        n_chk++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_pending: got rq=%b ov=%b want 0 0", imem_req_valid, out_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hdead_beef;
        step();
        imem_rsp_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped: got %b want 0", out_valid); end
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL rdw_new_addr: got v=%b a=%h want 1 80000100", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0020_0113;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0180;
        step();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || imem_req_addr !== 64'h8000_0180) begin n_fail++; $display("FAIL rdw_same_cycle: got ov=%b a=%h want 0 80000180", out_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_req;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0040;
        step();
        redirect_valid = 1'b0;
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0040) begin n_fail++; $display("FAIL rdr_addr: got v=%b a=%h want 1 80000040", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_double_redirect;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        step();
        imem_req_ready = 1'b0;
        redirect_pc    = 64'h8000_0400;
        step();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        step();
        imem_rsp_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0400) begin n_fail++; $display("FAIL dbl_addr: got ov=%b v=%b a=%h want 0 1 80000400", out_valid, imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2222_2222;
        step();
        imem_rsp_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0400 || out_instr !== 32'h2222_2222) begin n_fail++; $display("FAIL dbl_one_drop: got ov=%b pc=%h i=%h want 1 80000400 22222222", out_valid, out_pc, out_instr); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_misaligned;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_noreq: got %b want 0", imem_req_valid); end
        step();
        imem_req_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_pc !== 64'h8000_0102 || out_instr !== 32'h0) begin n_fail++; $display("FAIL mis_out: got v=%b f=%b pc=%h i=%h want 1 1 80000102 0", out_valid, out_fault, out_pc, out_instr); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0008;
        step();
        redirect_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_hold_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_err_redirect;
        n_chk++; if (imem_req_addr !== 64'h8000_0008) begin n_fail++; $display("FAIL err_addr: got %h want 80000008", imem_req_addr); end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        imem_rsp_data  = 32'hffff_ffff;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_instr !== 32'h0 || out_pc !== 64'h8000_0008) begin n_fail++; $display("FAIL err_out: got v=%b f=%b i=%h pc=%h want 1 1 0 80000008", out_valid, out_fault, out_instr, out_pc); end
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        step();
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        n_chk++; if (imem_req_addr !== 64'h8000_0200 || out_valid !== 1'b0) begin n_fail++; $display("FAIL err_hs_redirect: got a=%h ov=%b want 80000200 0", imem_req_addr, out_valid); end
    endtask

    task automatic test_wrap;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hffff_ffff_ffff_fffc;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0073;
        step();
        imem_rsp_valid = 1'b0;
        n_chk++; if (out_pc !== 64'hffff_ffff_ffff_fffc) begin n_fail++; $display("FAIL wrap_out_pc: got %h want fffffffffffffffc", out_pc); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_chk++; if (imem_req_addr !== 64'h0 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_addr: got v=%b a=%h want 1 0", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_reset_mid;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_during: got rq=%b ov=%b want 0 0", imem_req_valid, out_valid); end
        step();
        rst = 1'b0;
        #1;
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL midrst_after: got v=%b a=%h want 1 80000000", imem_req_valid, imem_req_addr); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3333_3333;
        step();
        imem_rsp_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_rsp: got %b want 0", out_valid); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_stalls();
        test_redirect_wait();
        test_redirect_req();
        test_double_redirect();
        test_misaligned();
        test_err_redirect();
        test_wrap();
        do_reset();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
